icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache immediately downstream of the pipelined datapath's fetch stage.
- Consumes imemREN/imemaddr; produces ihit/imemload. The datapath uses ihit to enable its pipeline registers.
- On a miss it requests one word from the memory controller (iREN/iaddr) and fills the frame once iwait drops.
- One-word blocks, no writes from the core.

Parameters:
- SETS, 16, number of frames; power of two, 2..256.
- IDX_W, $clog2(SETS), index width (derived, not overridable).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  fetch byte address.
- halt  input  1  datapath halt; when high, suppresses new fills.
- ihit  output  1  fetch word valid this cycle.
- imemload  output  32  fetched instruction.
- iREN  output  1  memory read request.
- iaddr  output  32  memory word address (bits[1:0]=0).
- iwait  input  1  memory busy; low means iload is valid this cycle.
- iload  input  32  memory read data.
- All core/memory signals are carried in the existing datapath_cache_if / caches_if modports; flat names are listed above.

Behaviour:
- Address split: tag = addr[31:2+IDX_W], idx = addr[2+IDX_W-1:2], addr[1:0] ignored. With SETS=16, tag is 26 bits.
- Frame storage: valid(1), tag, data(32) per set. Registers only, no SRAM macro.
- Reset (async, nRST=0):
  - All valid bits cleared; tag/data cleared to 0.
  - FSM to IDLE; miss address register cleared.
  - Outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
- FSM states:
  - IDLE: hit = imemREN & ~halt & valid[idx] & (tag[idx]==addr tag). ihit=hit, imemload=data[idx] when hit, else 0. Combinational, zero-cycle hit latency.
  - IDLE -> MISS when imemREN & ~halt & ~hit. Latch imemaddr with bits[1:0] forced to 0 into miss_addr.
  - MISS: iREN=1, iaddr=miss_addr, ihit=0, imemload=0.
  - MISS, iwait=1: stay in MISS.
  - MISS, iwait=0: write frame[miss_addr idx] = {1, miss tag, iload}, go to IDLE.
  - The next IDLE cycle hits. Miss latency = memory latency + 1 cycle.
- Boundary conditions:
  - imemaddr changes during MISS (e.g. flush redirect): the fill still completes to the latched miss_addr. IDLE then re-evaluates the new address.
  - halt rising during MISS: the in-flight fill completes; IDLE then stays idle with ihit=0.
  - imemREN=0 in IDLE: ihit=0, no request issued.
  - Conflict (same idx, different tag): the fill overwrites the frame; no replacement state.
  - iwait=0 in the very first MISS cycle: the fill takes effect at that edge; single-cycle miss penalty.
  - Reset asserted mid-MISS: the FSM aborts immediately, iREN drops asynchronously, and no frame is written.
- iREN is a registered-state output (function of the FSM only). It never toggles within a cycle due to iwait.

Decomposition:
- cpu_types_pkg gains:
  - icache_frame_t packed struct {valid, tag, data}.
  - icache_state_t enum {IC_IDLE, IC_MISS}.
  - ICACHE_SETS constant (16).
- One natural sub-module: icache_array (SETS frames; async read port by idx; single write port with WEN/idx/frame; async clear on nRST).
- The FSM and hit logic stay in icache_dm.

Test Plan:
- Reset, then fetch 0x00000000 with iwait held 2 cycles, iload=0x3C01DEAD -> iREN=1/iaddr=0x0 for 3 cycles; ihit=1, imemload=0x3C01DEAD on the following cycle.
- Refetch 0x00000000 after fill -> ihit=1 same cycle, iREN stays 0.
- Fetch 0x00000040 (same idx 0, tag 1) then 0x00000000 -> both miss. The second refill is requested at iaddr=0x0, showing eviction.
- Fetch 0x00000004 and change imemaddr to 0x00000008 mid-miss -> frame idx1 is filled with tag for 0x4. Then 0x8 misses with iaddr=0x8.
- Assert halt in IDLE with a valid hit address -> ihit=0 and iREN=0 while halt is held.
- Pull nRST low during MISS -> iREN=0 immediately. After release, refetching the same address misses again (valid was cleared).

Source files
------------

// File: rtl/icache_dm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_dm_pkg                                                    |
// | Shared types and constants for the direct-mapped icache.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package icache_dm_pkg;

  localparam int ICACHE_SETS      = 16;
  // Widest tag any legal set count can need (SETS >= 2 leaves 29 bits).
  localparam int ICACHE_TAG_MAX_W = 29;

  typedef struct packed {
    logic                        valid;
    logic [ICACHE_TAG_MAX_W-1:0] tag;
    logic [31:0]                 data;
  } icache_frame_t;

  typedef enum logic [0:0] {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } icache_state_t;

  // Tag of a word address, zero-extended to the common frame tag width.
  function automatic logic [ICACHE_TAG_MAX_W-1:0] icache_tag(input logic [29:0] waddr,
                                                             input int idx_w);
    return ICACHE_TAG_MAX_W'(waddr >> idx_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_dm_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_dm_if                                                     |
// | Fetch-side and memory-side signals of the instruction cache.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface icache_dm_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        halt;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  // The cache itself.
  modport slave (
    input  imemREN, imemaddr, halt, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  // The surrounding datapath and memory controller.
  modport master (
    output imemREN, imemaddr, halt, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface
`default_nettype wire

// File: rtl/icache_dm_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_dm_array                                                  |
// | Register-based frame store: async read by index, one write port. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module icache_dm_array
  import icache_dm_pkg::*;
#(
  parameter  int SETS  = ICACHE_SETS,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wen,
  input  logic [IDX_W-1:0] widx,
  input  icache_frame_t    wframe,
  input  logic [IDX_W-1:0] ridx,
  output icache_frame_t    rframe
);

  icache_frame_t w_frames [SETS];

  generate
    for (genvar s = 0; s < SETS; s++) begin : g_frame
      icache_frame_t r_frame;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          r_frame <= '0;
        end else if (wen && (widx == IDX_W'(s))) begin
          r_frame <= wframe;
        end
      end

      assign w_frames[s] = r_frame;
    end
  endgenerate

  assign rframe = w_frames[ridx];

endmodule
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_dm                                                        |
// | Direct-mapped read-only icache: zero-cycle hits, one-word fills. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter  int SETS  = ICACHE_SETS,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic      CLK,
  input  logic      nRST,
  icache_dm_if.slave bus
);

  icache_state_t               r_state;
  icache_state_t               w_next;
  logic [29:0]                 r_miss_waddr;
  logic [IDX_W-1:0]            w_ridx;
  logic [ICACHE_TAG_MAX_W-1:0] w_rtag;
  logic [ICACHE_TAG_MAX_W-1:0] w_mtag;
  icache_frame_t               w_rframe;
  icache_frame_t               w_wframe;
  logic                        w_req;
  logic                        w_hit;
  logic                        w_wen;
  logic                        w_unused;

  assign w_req    = bus.imemREN & ~bus.halt;
  assign w_ridx   = bus.imemaddr[2+IDX_W-1:2];
  assign w_rtag   = icache_tag(bus.imemaddr[31:2], IDX_W);
  assign w_mtag   = icache_tag(r_miss_waddr, IDX_W);
  assign w_hit    = (r_state == IC_IDLE) && w_req && w_rframe.valid && (w_rframe.tag == w_rtag);
  assign w_wframe = '{valid: 1'b1, tag: w_mtag, data: bus.iload};
  // Byte offset within the word plays no part in a word-granular fetch.
  assign w_unused = ^bus.imemaddr[1:0];

  icache_dm_array #(.SETS(SETS)) u_array (
    .CLK    (CLK),
    .nRST   (nRST),
    .wen    (w_wen),
    .widx   (r_miss_waddr[IDX_W-1:0]),
    .wframe (w_wframe),
    .ridx   (w_ridx),
    .rframe (w_rframe)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IC_IDLE;
      r_miss_waddr <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IC_IDLE) && w_req && !w_hit) begin
        r_miss_waddr <= bus.imemaddr[31:2];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IC_IDLE: if (w_req && !w_hit) w_next = IC_MISS;
      IC_MISS: if (!bus.iwait)      w_next = IC_IDLE;
      default: w_next = IC_IDLE;
    endcase
  end

  // Fill is written from the latched miss address, so a redirected fetch
  // address during the miss cannot corrupt the frame being filled.
  always_comb begin
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    w_wen        = 1'b0;
    case (r_state)
      IC_IDLE: begin
        bus.ihit = w_hit;
        if (w_hit) bus.imemload = w_rframe.data;
      end
      IC_MISS: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {r_miss_waddr, 2'b00};
        w_wen     = ~bus.iwait;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_icache_dm                                                     |
// | Scoreboard bench for icache_dm with a simple memory responder.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_icache_dm;

  logic        CLK = 1'b0;
  logic        nRST;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb [$];

  icache_dm_if bus ();

  icache_dm #(.SETS(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h3C01DEAD ^ {a[27:0], 4'h0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts just after a negedge. Miss: hit arrives lat+2 cycles later with
  // lat+1 request cycles. Redirect mode ends once the fill has retired.
  task automatic fetch(input logic [31:0] a, input int lat, input bit miss,
                       input logic [31:0] redir, input bit use_redir);
    int          n    = 0;
    int          mc   = 0;
    bit          done = 1'b0;
    logic [31:0] exp_d;
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    bus.halt     = 1'b0;
    if (!use_redir) sb.push_back(memword(a));
    while (!done && n < 40) begin
      #1;
      bus.iwait = 1'b1;
      bus.iload = '0;
      if (bus.ihit) begin
        check("hit_cycle", n, miss ? lat + 2 : 0);
        check("ren_cycles", mc, miss ? lat + 1 : 0);
        exp_d = sb.pop_front();
        check("imemload", bus.imemload, exp_d);
        done = 1'b1;
      end else if (bus.iREN) begin
        check("iaddr", bus.iaddr, {a[31:2], 2'b00});
        mc++;
        if (use_redir && mc == 1) bus.imemaddr = redir;
        if (mc > lat) begin
          bus.iwait = 1'b0;
          bus.iload = memword(bus.iaddr);
        end
      end else if (use_redir && mc > 0) begin
        check("redir_ren_cycles", mc, lat + 1);
        done = 1'b1;
      end
      if (!done) begin
        @(negedge CLK);
        n++;
      end
    end
    check("fetch_done", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.halt     = 1'b0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_ihit", bus.ihit, 0);
    check("rst_imemload", bus.imemload, 0);
    check("rst_iREN", bus.iREN, 0);
    check("rst_iaddr", bus.iaddr, 0);
    nRST = 1'b1;
    @(negedge CLK);

    fetch(32'h0000_0000, 2, 1'b1, '0, 1'b0);
    fetch(32'h0000_0000, 0, 1'b0, '0, 1'b0);
    // Conflict in idx 0, then single-cycle-penalty refill of the evicted word.
    fetch(32'h0000_0040, 1, 1'b1, '0, 1'b0);
    fetch(32'h0000_0000, 0, 1'b1, '0, 1'b0);
    fetch(32'h0000_0004, 1, 1'b1, 32'h0000_0008, 1'b1);
    fetch(32'h0000_0008, 1, 1'b1, '0, 1'b0);
    fetch(32'h0000_0004, 0, 1'b0, '0, 1'b0);
    fetch(32'h0000_0008, 0, 1'b0, '0, 1'b0);

    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0000_0000;
    #1;
    check("noreq_ihit", bus.ihit, 0);
    @(negedge CLK);
    #1;
    check("noreq_iREN", bus.iREN, 0);

    bus.imemREN = 1'b1;
    bus.halt    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("halt_ihit", bus.ihit, 0);
      check("halt_iREN", bus.iREN, 0);
      @(negedge CLK);
    end
    fetch(32'h0000_0000, 0, 1'b0, '0, 1'b0);

    bus.imemaddr = 32'h0000_000C;
    @(negedge CLK);
    #1;
    check("rstmiss_iREN_pre", bus.iREN, 1);
    nRST = 1'b0;
    #1;
    check("rstmiss_iREN_async", bus.iREN, 0);
    check("rstmiss_iaddr", bus.iaddr, 0);
    @(negedge CLK);
    nRST = 1'b1;
    fetch(32'h0000_000C, 1, 1'b1, '0, 1'b0);
    fetch(32'h0000_0000, 0, 1'b1, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
